// File: rtl/sif_pkg.sv
// Shared types for the butterfly pair issuer: FSM states, default
// component width, and the complex sample layout.
package sif_pkg;

    localparam int SIF_WIDTH = 16;

    typedef enum logic {
        FILL = 1'b0,
        PAIR = 1'b1
    } state_t;

    typedef struct packed {
        logic [SIF_WIDTH-1:0] re;
        logic [SIF_WIDTH-1:0] im;
    } cplx_t;

endpackage

// File: rtl/sif_bfly_pair_issue_if.sv
// Handshake bundle for the pair issuer: serial sample input plus the
// independent A/B operand channels. master = issuer side.
interface sif_bfly_pair_issue_if
    import sif_pkg::*;
#(
    parameter int WIDTH = SIF_WIDTH
);
    logic             in_vld;
    logic [WIDTH-1:0] in_real_dat;
    logic [WIDTH-1:0] in_img_dat;
    logic             in_rdy;

    logic             A_vld;
    logic [WIDTH-1:0] A_real_dat;
    logic [WIDTH-1:0] A_img_dat;
    logic             A_rdy;

    logic             B_vld;
    logic [WIDTH-1:0] B_real_dat;
    logic [WIDTH-1:0] B_img_dat;
    logic             B_rdy;

    modport master (
        input  in_vld, in_real_dat, in_img_dat,
        output in_rdy,
        output A_vld, A_real_dat, A_img_dat,
        input  A_rdy,
        output B_vld, B_real_dat, B_img_dat,
        input  B_rdy
    );

    modport slave (
        output in_vld, in_real_dat, in_img_dat,
        input  in_rdy,
        input  A_vld, A_real_dat, A_img_dat,
        output A_rdy,
        input  B_vld, B_real_dat, B_img_dat,
        output B_rdy
    );
endinterface

// File: rtl/sif_out_slot.sv
// Single-entry valid/ready holding register for one operand channel,
// carrying the data word and the end-of-frame flag.
module sif_out_slot
    import sif_pkg::*;
#(
    parameter int DW = 2 * SIF_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          load_last,
    input  logic          rdy,
    output logic          vld,
    output logic [DW-1:0] data,
    output logic          last,
    output logic          free
);
    logic          vld_reg;
    logic [DW-1:0] data_reg;
    logic          last_reg;

    // Free also when the held entry leaves this cycle, so load can overlap accept.
    assign free = ~vld_reg | rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_reg  <= 1'b0;
            data_reg <= '0;
            last_reg <= 1'b0;
        end else if (load) begin
            vld_reg  <= 1'b1;
            data_reg <= load_data;
            last_reg <= load_last;
        end else if (vld_reg && rdy) begin
            vld_reg  <= 1'b0;
            last_reg <= 1'b0;
        end
    end

    assign vld  = vld_reg;
    assign data = data_reg;
    assign last = last_reg;
endmodule

// File: rtl/sif_bfly_pair_issue.sv
// Buffers the first half-frame, then issues (x[i], x[i+HALF]) pairs on A/B.
// Optional macro SIF_PAIR_LAST_EN adds the pair_last output.
module sif_bfly_pair_issue
    import sif_pkg::*;
#(
    parameter int WIDTH = SIF_WIDTH,
    parameter int HALF  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sif_bfly_pair_issue_if.master bus,
`ifdef SIF_PAIR_LAST_EN
    output logic                 pair_last,
`endif
    output logic                 frame_done
);
    localparam int CNT_W = $clog2(HALF);
    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(HALF - 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   idx_reg, idx_next;
    logic [2*WIDTH-1:0] buf_mem [HALF];

    logic               in_rdy, in_accept, pair_load, at_last;
    logic [2*WIDTH-1:0] in_word;
    logic [1:0]         slot_vld, slot_rdy, slot_free, slot_last, last_acc;
    logic [2*WIDTH-1:0] slot_load_data [2];
    logic [2*WIDTH-1:0] slot_data [2];
    logic [1:0]         done_reg, done_next;
    logic               frame_done_reg, frame_done_next;

    assign in_word    = {bus.in_real_dat, bus.in_img_dat};
    assign in_rdy     = (state_reg == FILL) | (&slot_free);
    assign bus.in_rdy = in_rdy;
    assign in_accept  = bus.in_vld & in_rdy;
    assign at_last    = (idx_reg == IDX_LAST);
    assign pair_load  = in_accept & (state_reg == PAIR);

    // First-half storage; pair data is copied out on load, so refilling is safe.
    always_ff @(posedge clk) begin
        if (in_accept && state_reg == FILL) begin
            buf_mem[idx_reg] <= in_word;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        if (in_accept) begin
            idx_next = idx_reg + CNT_W'(1);
            if (at_last) begin
                state_next = (state_reg == FILL) ? PAIR : FILL;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= FILL;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    assign slot_load_data[0] = buf_mem[idx_reg];
    assign slot_load_data[1] = in_word;
    assign slot_rdy          = {bus.B_rdy, bus.A_rdy};

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_slot
        sif_out_slot #(.DW(2 * WIDTH)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (pair_load),
            .load_data (slot_load_data[gi]),
            .load_last (at_last),
            .rdy       (slot_rdy[gi]),
            .vld       (slot_vld[gi]),
            .data      (slot_data[gi]),
            .last      (slot_last[gi]),
            .free      (slot_free[gi])
        );
        assign last_acc[gi] = slot_vld[gi] & slot_rdy[gi] & slot_last[gi];
    end

    assign bus.A_vld                      = slot_vld[0];
    assign {bus.A_real_dat, bus.A_img_dat} = slot_data[0];
    assign bus.B_vld                      = slot_vld[1];
    assign {bus.B_real_dat, bus.B_img_dat} = slot_data[1];

    // Sticky per-channel "last pair accepted"; both clear when frame_done fires.
    always_comb begin
        done_next       = done_reg | last_acc;
        frame_done_next = &done_next;
        if (frame_done_next) begin
            done_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_reg       <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            done_reg       <= done_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign frame_done = frame_done_reg;
`ifdef SIF_PAIR_LAST_EN
    assign pair_last = |slot_last;
`endif
endmodule

// File: tb/tb_sif_bfly_pair_issue.sv
// Scoreboard bench for sif_bfly_pair_issue (HALF=4): directed frames,
// B stall, back-to-back frames, mid-frame reset and random handshakes.
module tb_sif_bfly_pair_issue;
    import sif_pkg::*;

    localparam int HALF = 4;
    localparam int W    = SIF_WIDTH;

    typedef struct {
        cplx_t d;
        bit    last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_done;
`ifdef SIF_PAIR_LAST_EN
    logic pair_last;
`endif

    sif_bfly_pair_issue_if #(.WIDTH(W)) bus ();

    sif_bfly_pair_issue #(.WIDTH(W), .HALF(HALF)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
`ifdef SIF_PAIR_LAST_EN
        .pair_last  (pair_last),
`endif
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    exp_t       qa[$];
    exp_t       qb[$];
    cplx_t      fh[HALF];
    cplx_t      next_sample;
    int         mcount, sample_k, acc_count, fd_count, a_pops;
    bit         exp_fd, last_a, last_b, hold_a, hold_b, quiet, rand_data;
    logic [2*W-1:0] held_a, held_b;

    task automatic gen_sample();
        if (rand_data) begin
            next_sample.re = W'($urandom);
            next_sample.im = W'($urandom);
        end else begin
            next_sample.re = W'(16'h3C00 + sample_k);
            next_sample.im = '0;
        end
        bus.in_real_dat = next_sample.re;
        bus.in_img_dat  = next_sample.im;
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        mcount = 0;
        exp_fd = 0; last_a = 0; last_b = 0; hold_a = 0; hold_b = 0;
        sample_k = 0;
        gen_sample();
    endtask

    // One clock: scoreboard compare at negedge, then step to just after posedge.
    task automatic tick();
        exp_t ea, eb;
        bit   exp_rdy;
        @(negedge clk);
        if (!rst) begin
            checks++;
            if (bus.A_vld !== (qa.size() != 0)) begin
                errors++; $display("FAIL a_vld: got %b want %b", bus.A_vld, qa.size() != 0);
            end
            checks++;
            if (bus.B_vld !== (qb.size() != 0)) begin
                errors++; $display("FAIL b_vld: got %b want %b", bus.B_vld, qb.size() != 0);
            end
            exp_rdy = (mcount < HALF) || ((qa.size() == 0 || bus.A_rdy) && (qb.size() == 0 || bus.B_rdy));
            checks++;
            if (bus.in_rdy !== exp_rdy) begin
                errors++; $display("FAIL in_rdy: got %b want %b", bus.in_rdy, exp_rdy);
            end
            checks++;
            if (frame_done !== exp_fd) begin
                errors++; $display("FAIL frame_done: got %b want %b", frame_done, exp_fd);
            end
`ifdef SIF_PAIR_LAST_EN
            checks++;
            if (pair_last !== ((qa.size() != 0 && qa[0].last) || (qb.size() != 0 && qb[0].last))) begin
                errors++; $display("FAIL pair_last: got %b want %b", pair_last,
                    (qa.size() != 0 && qa[0].last) || (qb.size() != 0 && qb[0].last));
            end
`endif
            if (hold_a) begin
                checks++;
                if (bus.A_vld !== 1'b1 || {bus.A_real_dat, bus.A_img_dat} !== held_a) begin
                    errors++; $display("FAIL a_stable: got vld=%b data=%h want vld=1 data=%h",
                        bus.A_vld, {bus.A_real_dat, bus.A_img_dat}, held_a);
                end
            end
            if (hold_b) begin
                checks++;
                if (bus.B_vld !== 1'b1 || {bus.B_real_dat, bus.B_img_dat} !== held_b) begin
                    errors++; $display("FAIL b_stable: got vld=%b data=%h want vld=1 data=%h",
                        bus.B_vld, {bus.B_real_dat, bus.B_img_dat}, held_b);
                end
            end
            if (frame_done) fd_count++;
            exp_fd = 0;
            if (bus.A_vld && bus.A_rdy && qa.size() != 0) begin
                ea = qa.pop_front();
                a_pops++;
                checks++;
                if ({bus.A_real_dat, bus.A_img_dat} !== {ea.d.re, ea.d.im}) begin
                    errors++; $display("FAIL a_data: got %h_%h want %h_%h",
                        bus.A_real_dat, bus.A_img_dat, ea.d.re, ea.d.im);
                end
                if (ea.last) last_a = 1;
                if (!quiet) $display("A accept re=%h im=%h last=%0d", bus.A_real_dat, bus.A_img_dat, ea.last);
            end
            if (bus.B_vld && bus.B_rdy && qb.size() != 0) begin
                eb = qb.pop_front();
                checks++;
                if ({bus.B_real_dat, bus.B_img_dat} !== {eb.d.re, eb.d.im}) begin
                    errors++; $display("FAIL b_data: got %h_%h want %h_%h",
                        bus.B_real_dat, bus.B_img_dat, eb.d.re, eb.d.im);
                end
                if (eb.last) last_b = 1;
                if (!quiet) $display("B accept re=%h im=%h last=%0d", bus.B_real_dat, bus.B_img_dat, eb.last);
            end
            if (last_a && last_b) begin
                exp_fd = 1; last_a = 0; last_b = 0;
            end
            hold_a = bus.A_vld && !bus.A_rdy;
            held_a = {bus.A_real_dat, bus.A_img_dat};
            hold_b = bus.B_vld && !bus.B_rdy;
            held_b = {bus.B_real_dat, bus.B_img_dat};
            if (bus.in_vld && bus.in_rdy) begin
                if (mcount < HALF) begin
                    fh[mcount] = next_sample;
                end else begin
                    ea.d = fh[mcount - HALF]; ea.last = (mcount == 2 * HALF - 1);
                    eb.d = next_sample;       eb.last = ea.last;
                    qa.push_back(ea);
                    qb.push_back(eb);
                end
                mcount = (mcount + 1) % (2 * HALF);
                acc_count++;
                sample_k++;
            end
        end
        @(posedge clk);
        #1;
        if (!rst) gen_sample();
    endtask

    task automatic feed(input int n, input bit rnd);
        int target;
        int budget;
        target = acc_count + n;
        budget = 0;
        while (acc_count < target && budget < 60000) begin
            if (rnd) begin
                bus.in_vld = ($urandom_range(3) != 0);
                bus.A_rdy  = ($urandom_range(9) < 7);
                bus.B_rdy  = ($urandom_range(9) < 7);
            end else begin
                bus.in_vld = 1'b1;
                bus.A_rdy  = 1'b1;
                bus.B_rdy  = 1'b1;
            end
            tick();
            budget++;
        end
        bus.in_vld = 1'b0;
        checks++;
        if (acc_count < target) begin
            errors++; $display("FAIL feed_timeout: accepted %0d want %0d", acc_count, target);
        end
    endtask

    task automatic drain();
        bus.in_vld = 1'b0;
        bus.A_rdy  = 1'b1;
        bus.B_rdy  = 1'b1;
        for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) tick();
        tick();
        tick();
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++; $display("FAIL drain: pending a=%0d b=%0d want 0", qa.size(), qb.size());
        end
    endtask

    task automatic test_reset();
        bus.in_vld = 1'b0; bus.A_rdy = 1'b0; bus.B_rdy = 1'b0;
        rand_data = 0; quiet = 0; acc_count = 0; fd_count = 0; a_pops = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.A_vld !== 1'b0 || bus.B_vld !== 1'b0) begin
            errors++; $display("FAIL reset_vld: got a=%b b=%b want 0 0", bus.A_vld, bus.B_vld);
        end
        checks++;
        if (frame_done !== 1'b0 || bus.in_rdy !== 1'b1) begin
            errors++; $display("FAIL reset_ctl: got fd=%b in_rdy=%b want 0 1", frame_done, bus.in_rdy);
        end
        checks++;
        if (bus.A_real_dat !== '0 || bus.B_real_dat !== '0 || bus.A_img_dat !== '0 || bus.B_img_dat !== '0) begin
            errors++; $display("FAIL reset_data: got A=%h B=%h want 0 0", bus.A_real_dat, bus.B_real_dat);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        int fd0, p0;
        fd0 = fd_count; p0 = a_pops;
        feed(2 * HALF, 0);
        drain();
        checks++;
        if (fd_count - fd0 != 1 || a_pops - p0 != HALF) begin
            errors++; $display("FAIL stream: got fd=%0d pairs=%0d want 1 %0d", fd_count - fd0, a_pops - p0, HALF);
        end
    endtask

    task automatic test_b_stall();
        int fd0, acc0;
        fd0 = fd_count;
        sample_k = 0; gen_sample();
        feed(HALF + 2, 0);
        bus.in_vld = 1'b1; bus.A_rdy = 1'b1; bus.B_rdy = 1'b0;
        acc0 = acc_count;
        repeat (3) tick();
        checks++;
        if (bus.A_vld !== 1'b0 || bus.B_vld !== 1'b1 || bus.in_rdy !== 1'b0) begin
            errors++; $display("FAIL b_stall_ctl: got a=%b b=%b in_rdy=%b want 0 1 0", bus.A_vld, bus.B_vld, bus.in_rdy);
        end
        checks++;
        if (bus.B_real_dat !== 16'h3C05 || acc_count != acc0) begin
            errors++; $display("FAIL b_stall_data: got %h acc+%0d want 3c05 acc+0", bus.B_real_dat, acc_count - acc0);
        end
        feed(HALF - 2, 0);
        drain();
        checks++;
        if (fd_count - fd0 != 1) begin
            errors++; $display("FAIL b_stall_done: got %0d want 1", fd_count - fd0);
        end
    endtask

    task automatic test_back_to_back();
        int fd0;
        fd0 = fd_count;
        sample_k = 0; gen_sample();
        feed(4 * HALF, 0);
        drain();
        checks++;
        if (fd_count - fd0 != 2) begin
            errors++; $display("FAIL back_to_back: frame_done pulses %0d want 2", fd_count - fd0);
        end
    endtask

    task automatic test_reset_mid();
        int fd0;
        sample_k = 0; gen_sample();
        feed(HALF + 2, 0);
        bus.A_rdy = 1'b0; bus.B_rdy = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.A_vld !== 1'b0 || bus.B_vld !== 1'b0 || frame_done !== 1'b0) begin
            errors++; $display("FAIL reset_mid: got a=%b b=%b fd=%b want 0 0 0", bus.A_vld, bus.B_vld, frame_done);
        end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        fd0 = fd_count;
        feed(2 * HALF, 0);
        drain();
        checks++;
        if (fd_count - fd0 != 1) begin
            errors++; $display("FAIL reset_mid_frame: frame_done pulses %0d want 1", fd_count - fd0);
        end
    endtask

    task automatic test_random();
        int fd0;
        quiet = 1; rand_data = 1;
        sample_k = 0; gen_sample();
        fd0 = fd_count;
        feed(2 * HALF * 1000, 1);
        drain();
        checks++;
        if (fd_count - fd0 != 1000) begin
            errors++; $display("FAIL random_frames: frame_done pulses %0d want 1000", fd_count - fd0);
        end
        quiet = 0; rand_data = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_b_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sif_bfly_pair_issue.md
Name: sif_bfly_pair_issue

Overview:
- Initiator side of the complex half-precision add/sub operand interface.
- Accepts one serial stream of complex FP16 samples per frame of 2*HALF samples.
- Buffers the first half of the frame, then issues butterfly operand pairs (x[i], x[i+HALF]) on independent A and B valid/ready channels to the downstream complex adder/subtractor.
- Sits between the sample buffer read port and the complex add/sub stage.

Parameters:
- WIDTH, 16, bit width of each real/imag component (FP16 raw bits; passed through untouched).
- HALF, 8, samples per half-frame; power of two, minimum 2.
- CNT_W, $clog2(HALF), localparam; index counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- in_vld  in  1  input sample valid.
- in_real_dat  in  WIDTH  input sample real part.
- in_img_dat  in  WIDTH  input sample imaginary part.
- in_rdy  out  1  input sample accepted when in_vld & in_rdy.
- A_vld  out  1  operand A valid.
- A_real_dat  out  WIDTH  operand A real (x[i]).
- A_img_dat  out  WIDTH  operand A imaginary.
- A_rdy  in  1  downstream accepts A.
- B_vld  out  1  operand B valid.
- B_real_dat  out  WIDTH  operand B real (x[i+HALF]).
- B_img_dat  out  WIDTH  operand B imaginary.
- B_rdy  in  1  downstream accepts B.
- frame_done  out  1  one-cycle pulse when both operands of the final pair of a frame have been accepted.

Behaviour:
- Reset (async, rst=1): FSM=FILL, idx=0, A_vld=0, B_vld=0, frame_done=0, A/B data=0, buffer contents don't-care. in_rdy=1 in FILL after reset.
- FSM states: FILL, PAIR.
- FILL:
  - in_rdy=1 unconditionally.
  - Each accepted sample is written to buf[idx]; idx increments.
  - When the sample at idx==HALF-1 is accepted, idx wraps to 0 and the FSM goes to PAIR.
- PAIR:
  - in_rdy = slotA_free & slotB_free, where a slot is free if its valid is 0 or it is being accepted this cycle (vld & rdy). Combinational ready is permitted; the rdy-to-rdy path is intended.
  - On accept: A regs <= buf[idx], B regs <= input sample, A_vld=B_vld=1 next cycle, idx++.
  - Accepting the sample at idx==HALF-1 marks the pair as last; idx wraps to 0 and the FSM returns to FILL the next cycle.
- Latency: 1 cycle from second-half input accept to A_vld/B_vld high.
- A and B are independent channels:
  - Each valid stays high with stable data until its own rdy is seen.
  - A may be accepted before B or vice versa; a new pair loads only when both slots are free.
- Simultaneous load and accept on a slot in the same cycle: new data loads and valid stays 1 (full throughput, one pair per cycle when A_rdy=B_rdy=1).
- FILL of the next frame may proceed while the last pair is still pending on A/B. Buffer writes cannot corrupt the pending pair, because the pair data sits in the output regs.
- frame_done:
  - Asserts the cycle after the later of the two acceptances of the last pair, via a per-channel "last accepted" sticky bit.
  - Both sticky bits clear together when frame_done fires.
- Reset mid-frame: all state is discarded and pending operands are dropped (valids low immediately).
- No arithmetic; data is passed bit-exact.

Optional Feature:
- Macro SIF_PAIR_LAST_EN.
- Defined: adds output port pair_last (1 bit), registered with the A/B slots. It is high while the final pair of a frame is held in the slots, and each slot carries its own copy, cleared on that slot's accept. pair_last = lastA | lastB.
- Undefined: port absent; frame_done behaviour unchanged.

Decomposition:
- Package sif_pkg:
  - FSM state enum (FILL, PAIR).
  - default WIDTH constant.
  - typedef for a complex sample struct {real, img}.
- Sub-module sif_out_slot: single-entry valid/ready holding register carrying data and the last flag. It exposes a free signal and is instantiated twice, for A and B.

Test Plan:
- HALF=4, A_rdy=B_rdy=1, inputs real=0x3C00+k for k=0..7, img=0 -> pairs (k, k+4) for k=0..3 on A/B on consecutive cycles, one frame_done after pair 3 is accepted.
- B_rdy held 0 for 3 cycles during pair 1, A_rdy=1 -> A accepted immediately; B holds stable; in_rdy=0 until B is accepted; no pair lost or duplicated.
- Back-to-back frames, 16 samples, continuous in_vld -> FILL of frame 2 overlaps the pending last pair of frame 1; output order correct; exactly 2 frame_done pulses.
- rst asserted mid-PAIR (after 2 pairs) -> A_vld=B_vld=0 asynchronously; the next 8 samples form a fresh, correct frame.
- Random A_rdy/B_rdy/in_vld over 1000 frames -> scoreboard matches x[i]/x[i+HALF]; data stable while vld & !rdy.
- SIF_PAIR_LAST_EN defined -> pair_last is high only with pair (3,7); it clears after both slots are accepted.
